xps2: RTL and testbench

Memory-mapped PS/2 keyboard receiver for the calculator data bus. It deserialises PS/2 device-to-host frames, checks framing and parity, and buffers scan codes in a small FIFO. The controller polls the FIFO through two word registers on the data bus: it selects the block with `data_sel`, and the block answers combinationally on the controller's `data_to_rd` path.

---
 rtl/xps2_pkg.sv | 31 +++
 rtl/xps2_fifo.sv | 55 +++++
 rtl/xps2.sv | 191 +++++++++++++++++++
 tb/tb_xps2.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/xps2_pkg.sv
// Shared definitions for the xps2 PS/2 keyboard receiver: register offsets,
// STATUS/DATA bit positions, receive FSM encoding and the break prefix.
package xps2_pkg;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    localparam int ST_NE      = 0;
    localparam int ST_OVF     = 1;
    localparam int ST_ERR     = 2;
    localparam int ST_CNT_LSB = 4;

    localparam int DAT_BRK = 8;
    localparam int DAT_VLD = 31;

    localparam int         ENTRY_W    = 9;
    localparam logic [7:0] BRK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // PS/2 uses odd parity across the 8 data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/xps2_fifo.sv
// Synchronous FIFO for received scan codes; head is presented combinationally.
// Simultaneous push/pop always succeed, even when full; pop while empty is ignored.
module xps2_fifo #(
    parameter int W  = 9,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == FULL_CNT);
    assign count     = r_cnt;
    assign dout      = r_mem[r_rd];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/xps2.sv
// Memory-mapped PS/2 keyboard receiver: pin sync, frame FSM, timeout, FIFO, STATUS/DATA regs.
// Optional feature: define PS2_BREAK_MERGE_EN to fold the F0 break prefix into bit8 of the next code.
module xps2
    import xps2_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic              addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              ps2_clk,
    input  logic              ps2_data
);

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic r_clk_s1, r_clk_s2, r_clk_d;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    // Pins idle high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_d & ~r_clk_s2;

    rx_state_t       r_state;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shreg;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_stop_edge;
    logic            w_frame_ok;
    logic            w_good;
    logic            w_bad;

    assign w_timeout   = (r_state != RX_IDLE) & ~w_fall & (r_to_cnt == TO_LAST);
    assign w_stop_edge = (r_state == RX_STOP) & w_fall;
    assign w_frame_ok  = r_dat_s2 & odd_parity_ok(r_shreg, r_par);
    assign w_good      = w_stop_edge & w_frame_ok;
    assign w_bad       = w_stop_edge & ~w_frame_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                RX_IDLE: begin
                    r_to_cnt <= '0;
                    r_bitcnt <= '0;
                    if (w_fall && !r_dat_s2) r_state <= RX_DATA;
                end
                default: begin
                    if (w_timeout) begin
                        r_state  <= RX_IDLE;
                        r_to_cnt <= '0;
                        r_bitcnt <= '0;
                        r_shreg  <= '0;
                    end else if (w_fall) begin
                        r_to_cnt <= '0;
                        case (r_state)
                            RX_DATA: begin
                                r_shreg  <= {r_dat_s2, r_shreg[7:1]};
                                r_bitcnt <= r_bitcnt + 1'b1;
                                if (r_bitcnt == 3'd7) r_state <= RX_PARITY;
                            end
                            RX_PARITY: begin
                                r_par   <= r_dat_s2;
                                r_state <= RX_STOP;
                            end
                            default: r_state <= RX_IDLE;
                        endcase
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;
    logic               w_empty;
    logic               w_full;
    logic [FIFO_AW:0]   w_count;

`ifdef PS2_BREAK_MERGE_EN
    logic r_brk_pend;
    logic w_is_brk;

    assign w_is_brk = (r_shreg == BRK_PREFIX);
    assign w_push   = w_good & ~w_is_brk;
    assign w_din    = {r_brk_pend, r_shreg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  r_brk_pend <= 1'b0;
        else if (w_bad | w_timeout) r_brk_pend <= 1'b0;
        else if (w_good)           r_brk_pend <= w_is_brk;
    end
`else
    assign w_push = w_good;
    assign w_din  = {1'b0, r_shreg};
`endif

    assign w_pop = sel & ~we & (addr == ADDR_DATA);

    xps2_fifo #(
        .W  (ENTRY_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    logic r_ovf, r_err;
    logic w_st_wr;
    logic w_ovf_set;
    logic w_err_set;
    logic w_unused_wdata;

    assign w_st_wr        = sel & we & (addr == ADDR_STATUS);
    assign w_ovf_set      = w_push & w_full & ~w_pop;
    assign w_err_set      = w_bad | w_timeout;
    assign w_unused_wdata = ^{data_in[DATA_W-1:3], data_in[0]};

    // A set event in the same cycle as a software clear takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_ovf_set)                     r_ovf <= 1'b1;
            else if (w_st_wr && data_in[ST_OVF]) r_ovf <= 1'b0;
            if (w_err_set)                     r_err <= 1'b1;
            else if (w_st_wr && data_in[ST_ERR]) r_err <= 1'b0;
        end
    end

    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_data;

    always_comb begin
        w_status                  = '0;
        w_status[ST_NE]           = ~w_empty;
        w_status[ST_OVF]          = r_ovf;
        w_status[ST_ERR]          = r_err;
        w_status[ST_CNT_LSB +: 4] = 4'(w_count);
        w_data                    = '0;
        if (!w_empty) begin
            w_data[DAT_VLD]   = 1'b1;
            w_data[DAT_BRK:0] = w_dout;
        end
    end

    assign data_out = (addr == ADDR_DATA) ? w_data : w_status;

endmodule

// File: tb/tb_xps2.sv
// Directed bench for xps2: table of single-frame vectors plus overflow, timeout,
// simultaneous push/pop and mid-frame reset sequences.
module tb_xps2;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic        addr = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;

    xps2 #(
        .DATA_W      (32),
        .FIFO_AW     (3),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  code;
        logic        par;
        logic        stop;
        logic [31:0] exp_st;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = a;
        #1 d = data_out;
        @(posedge clk);
        #1 sel = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic a, input logic [31:0] v);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; addr = a; data_in = v;
        @(posedge clk);
        #1 sel = 1'b0; we = 1'b0; data_in = '0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] c, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        send_bit(p);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic p, input logic s);
        send_head(c, p);
        send_bit(s);
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    function automatic logic opar(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        logic [31:0] d;

        vecs[0] = '{8'h1C, 1'b0, 1'b1, 32'h11, 32'h8000001C};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 32'h04, 32'h00000000};
        vecs[2] = '{8'h5A, 1'b1, 1'b1, 32'h11, 32'h8000005A};
        vecs[3] = '{8'h5A, 1'b0, 1'b1, 32'h04, 32'h00000000};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 32'h11, 32'h80000000};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 32'h11, 32'h800000FF};
        vecs[6] = '{8'h1C, 1'b0, 1'b0, 32'h04, 32'h00000000};
`ifdef PS2_BREAK_MERGE_EN
        vecs[7] = '{8'hF0, 1'b1, 1'b1, 32'h00, 32'h00000000};
        vecs[8] = '{8'h1C, 1'b0, 1'b1, 32'h11, 32'h8000011C};
`else
        vecs[7] = '{8'hF0, 1'b1, 1'b1, 32'h11, 32'h800000F0};
        vecs[8] = '{8'h1C, 1'b0, 1'b1, 32'h11, 32'h8000001C};
`endif

        // Reset state, read while reset is held and after release
        repeat (5) @(negedge clk);
        addr = 1'b0; #1 check("rst_status", data_out, 32'h0);
        addr = 1'b1; #1 check("rst_data", data_out, 32'h0);
        @(negedge clk) rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_rd("post_rst_status", 1'b0, 32'h0);
        chk_rd("post_rst_data", 1'b1, 32'h0);

        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].code, vecs[v].par, vecs[v].stop);
            repeat (5) @(negedge clk);
            chk_rd($sformatf("vec%0d_status", v), 1'b0, vecs[v].exp_st);
            chk_rd($sformatf("vec%0d_data", v), 1'b1, vecs[v].exp_dat);
            chk_rd($sformatf("vec%0d_status_after", v), 1'b0, vecs[v].exp_st & 32'h6);
            wr(1'b0, 32'h6);
            chk_rd($sformatf("vec%0d_status_clr", v), 1'b0, 32'h0);
        end

        // Overflow: nine frames, no reads
        for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), opar(8'h10 + 8'(i)), 1'b1);
        chk_rd("ovf_status", 1'b0, 32'h83);
        for (int i = 0; i < 8; i++)
            chk_rd($sformatf("ovf_data%0d", i), 1'b1, 32'h80000010 + 32'(i));
        chk_rd("ovf_status_drained", 1'b0, 32'h02);
        chk_rd("ovf_ninth_absent", 1'b1, 32'h0);
        wr(1'b0, 32'h2);
        chk_rd("ovf_clr", 1'b0, 32'h0);

        // Timeout mid-frame, then a spurious idle edge, then a clean frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (TO + 1) @(negedge clk);
        chk_rd("timeout_err", 1'b0, 32'h04);
        wr(1'b0, 32'h4);
        chk_rd("timeout_clr", 1'b0, 32'h0);
        send_bit(1'b1);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk_rd("after_to_status", 1'b0, 32'h11);
        chk_rd("after_to_data", 1'b1, 32'h8000005A);

        // Full FIFO, DATA read lands in the same cycle as the push
        for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), opar(8'h20 + 8'(i)), 1'b1);
        chk_rd("full_status", 1'b0, 32'h81);
        send_head(8'h30, opar(8'h30));
        @(negedge clk) ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sel = 1'b1; we = 1'b0; addr = 1'b1;
        #1 d = data_out;
        @(posedge clk);
        #1 sel = 1'b0;
        check("simul_head", d, 32'h80000020);
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        chk_rd("simul_status", 1'b0, 32'h81);
        for (int i = 1; i < 8; i++)
            chk_rd($sformatf("simul_data%0d", i), 1'b1, 32'h80000020 + 32'(i));
        chk_rd("simul_new_entry", 1'b1, 32'h80000030);
        chk_rd("simul_empty", 1'b0, 32'h0);

        // Reset in the middle of a frame with flags and data pending
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk_rd("pre_rst_status", 1'b0, 32'h15);
        send_bit(1'b0);
        send_bit(1'b1);
        @(negedge clk) rst = 1'b0;
        addr = 1'b0; #1 check("midrst_status", data_out, 32'h0);
        addr = 1'b1; #1 check("midrst_data", data_out, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (TO + 20) @(negedge clk);
        chk_rd("midrst_idle_status", 1'b0, 32'h0);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk_rd("midrst_next_status", 1'b0, 32'h11);
        chk_rd("midrst_next_data", 1'b1, 32'h8000005A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
